// File: rtl/hm2_capsense_pkg.sv
// Shared state encoding and default constants for the capacitive-touch scanner.
package hm2_capsense_pkg;

  // Mirrors NumCapSense in the board package.
  localparam int unsigned NUM_CAP_SENSE    = 4;
  localparam int unsigned DEF_CNT_W        = 16;
  localparam int unsigned DEF_DISCH_CYCLES = 64;
  localparam int unsigned DEF_MAX_COUNT    = 'hFFF0;
  localparam int unsigned DEF_BASE_SHIFT   = 4;

  typedef enum logic [1:0] {
    IDLE,
    DISCHARGE,
    CHARGE,
    LATCH
  } state_t;

endpackage

// File: rtl/hm2_capsense_chan.sv
// One sense channel: pad synchroniser, charge-time capture, hysteresis touch flag.
// Optional per-channel baseline tracking under HM2_CAPSENSE_BASELINE_EN.
module hm2_capsense_chan
  import hm2_capsense_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned MAX_COUNT  = DEF_MAX_COUNT
`ifdef HM2_CAPSENSE_BASELINE_EN
  ,parameter int unsigned BASE_SHIFT = DEF_BASE_SHIFT
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pad_in,
  input  logic             charge,
  input  logic             latch,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] threshold,
  input  logic [CNT_W-1:0] hysteresis,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             timeout,
  output logic             touched
`ifdef HM2_CAPSENSE_BASELINE_EN
  ,output logic [CNT_W-1:0] baseline
`endif
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cap;
  logic [CNT_W-1:0] cnt_v;
  logic [CNT_W-1:0] eff_thr;
  logic [CNT_W-1:0] rel_thr;

`ifdef HM2_CAPSENSE_BASELINE_EN
  logic                    base_init;
  logic [CNT_W-1:0]        base_ref;
  logic [CNT_W:0]          thr_sum;
  logic signed [CNT_W:0]   base_s;
  logic signed [CNT_W:0]   diff;
  logic signed [CNT_W:0]   step;
  logic [CNT_W-1:0]        base_upd;
`endif

  always_comb begin
    cnt_v = done ? cap : MAX_C;
`ifdef HM2_CAPSENSE_BASELINE_EN
    // Before the first load the baseline is taken as the count itself.
    base_ref = base_init ? baseline : cnt_v;
    thr_sum  = {1'b0, base_ref} + {1'b0, threshold};
    eff_thr  = (thr_sum > {1'b0, MAX_C}) ? MAX_C : thr_sum[CNT_W-1:0];
    base_s   = $signed({1'b0, baseline});
    diff     = $signed({1'b0, cnt_v}) - base_s;
    step     = diff >>> BASE_SHIFT;
    base_upd = CNT_W'($unsigned(base_s + step));
`else
    eff_thr  = threshold;
`endif
    rel_thr = (hysteresis >= eff_thr) ? '0 : eff_thr - hysteresis;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= '0;
      cap     <= '0;
      done    <= 1'b0;
      count   <= '0;
      timeout <= 1'b0;
      touched <= 1'b0;
`ifdef HM2_CAPSENSE_BASELINE_EN
      baseline  <= '0;
      base_init <= 1'b0;
`endif
    end else begin
      sync <= {sync[0], pad_in};
      if (charge && sync[1] && !done) begin
        cap  <= cnt;
        done <= 1'b1;
      end
      if (latch) begin
        count   <= cnt_v;
        timeout <= !done;
        done    <= 1'b0;
        if (cnt_v >= eff_thr)
          touched <= 1'b1;
        else if (cnt_v < rel_thr)
          touched <= 1'b0;
`ifdef HM2_CAPSENSE_BASELINE_EN
        if (!base_init) begin
          baseline  <= cnt_v;
          base_init <= 1'b1;
        end else if (!touched) begin
          baseline <= base_upd;
        end
`endif
      end
    end
  end

endmodule

// File: rtl/hm2_capsense_scan.sv
// Parametrised capacitive-touch scanner: scan FSM and shared charge counter.
// Build option HM2_CAPSENSE_BASELINE_EN adds per-channel baseline tracking.
module hm2_capsense_scan
  import hm2_capsense_pkg::*;
#(
  parameter int unsigned NUM_CH       = NUM_CAP_SENSE,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned DISCH_CYCLES = DEF_DISCH_CYCLES,
  parameter int unsigned MAX_COUNT    = DEF_MAX_COUNT
`ifdef HM2_CAPSENSE_BASELINE_EN
  ,parameter int unsigned BASE_SHIFT  = DEF_BASE_SHIFT
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       pad_in,
  output logic [NUM_CH-1:0]       pad_oe,
  input  logic [CNT_W-1:0]        threshold,
  input  logic [CNT_W-1:0]        hysteresis,
  output logic [NUM_CH*CNT_W-1:0] count_out,
  output logic [NUM_CH-1:0]       timeout,
  output logic [NUM_CH-1:0]       touched,
  output logic                    sample_valid
`ifdef HM2_CAPSENSE_BASELINE_EN
  ,output logic [NUM_CH*CNT_W-1:0] baseline_out
`endif
);

  localparam int unsigned       DW         = $clog2(DISCH_CYCLES + 1);
  localparam logic [DW-1:0]     DISCH_LAST = DW'(DISCH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  MAX_C      = CNT_W'(MAX_COUNT);

  state_t            state, state_nx;
  logic [DW-1:0]     disch_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] done;
  logic              charge;
  logic              latch;

  assign charge = (state == CHARGE);
  assign latch  = (state == LATCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      disch_cnt    <= '0;
      cnt          <= '0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      sample_valid <= latch;
      disch_cnt    <= (state == DISCHARGE) ? disch_cnt + DW'(1) : '0;
      // Counter parks at MAX_COUNT, so it can never wrap.
      if (charge) begin
        if (cnt != MAX_C)
          cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    pad_oe   = '0;
    unique case (state)
      IDLE:
        if (enable)
          state_nx = DISCHARGE;
      DISCHARGE: begin
        pad_oe = '1;
        if (disch_cnt == DISCH_LAST)
          state_nx = CHARGE;
      end
      CHARGE:
        if ((&done) || (cnt == MAX_C))
          state_nx = LATCH;
      LATCH:
        state_nx = enable ? DISCHARGE : IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    hm2_capsense_chan #(
      .CNT_W     (CNT_W),
      .MAX_COUNT (MAX_COUNT)
`ifdef HM2_CAPSENSE_BASELINE_EN
      ,.BASE_SHIFT(BASE_SHIFT)
`endif
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .pad_in     (pad_in[i]),
      .charge     (charge),
      .latch      (latch),
      .cnt        (cnt),
      .threshold  (threshold),
      .hysteresis (hysteresis),
      .done       (done[i]),
      .count      (count_out[i*CNT_W +: CNT_W]),
      .timeout    (timeout[i]),
      .touched    (touched[i])
`ifdef HM2_CAPSENSE_BASELINE_EN
      ,.baseline  (baseline_out[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_hm2_capsense_scan.sv
// Scoreboard bench for hm2_capsense_scan (NUM_CH=4, DISCH_CYCLES=8, MAX_COUNT=500).
module tb_hm2_capsense_scan;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CW   = 16;
  localparam int          MAXC = 500;
  localparam int          SHF  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [NCH-1:0]    pad_in;
  logic [NCH-1:0]    pad_oe;
  logic [CW-1:0]     threshold;
  logic [CW-1:0]     hysteresis;
  logic [NCH*CW-1:0] count_out;
  logic [NCH-1:0]    timeout;
  logic [NCH-1:0]    touched;
  logic              sample_valid;
`ifdef HM2_CAPSENSE_BASELINE_EN
  logic [NCH*CW-1:0] baseline_out;
`endif

  always #5 clk = ~clk;

  hm2_capsense_scan #(
    .NUM_CH       (NCH),
    .CNT_W        (CW),
    .DISCH_CYCLES (8),
    .MAX_COUNT    (MAXC)
`ifdef HM2_CAPSENSE_BASELINE_EN
    ,.BASE_SHIFT  (SHF)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pad_in       (pad_in),
    .pad_oe       (pad_oe),
    .threshold    (threshold),
    .hysteresis   (hysteresis),
    .count_out    (count_out),
    .timeout      (timeout),
    .touched      (touched),
    .sample_valid (sample_valid)
`ifdef HM2_CAPSENSE_BASELINE_EN
    ,.baseline_out(baseline_out)
`endif
  );

  typedef struct packed {
    logic [NCH-1:0][CW-1:0] cnt;
    logic [NCH-1:0]         tmo;
    logic [NCH-1:0]         tch;
    logic [NCH-1:0][CW-1:0] base;
  } exp_t;

  exp_t           sb[$];
  int             checks = 0;
  int             errors = 0;
  logic [NCH-1:0] m_touch;
  logic [CW-1:0]  m_base [NCH];
  bit             m_init;

  task automatic model_reset();
    m_touch = '0;
    m_init  = 1'b0;
    for (int ch = 0; ch < NCH; ch++) m_base[ch] = '0;
    sb.delete();
  endtask

  // r[ch] = CHARGE cycle on which pad ch is driven high; negative = never.
  task automatic run_scan(input int r0, input int r1, input int r2, input int r3);
    int   r [NCH];
    exp_t e;
    int   c, eff, rel, b, n, cyc;
    logic old;
    r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
    for (int ch = 0; ch < NCH; ch++) begin
      c = (r[ch] < 0) ? MAXC : r[ch] + 2;
      e.cnt[ch] = CW'(c);
      e.tmo[ch] = (r[ch] < 0);
`ifdef HM2_CAPSENSE_BASELINE_EN
      eff = (m_init ? int'(m_base[ch]) : c) + int'(threshold);
      if (eff > MAXC) eff = MAXC;
`else
      eff = int'(threshold);
`endif
      rel = (int'(hysteresis) >= eff) ? 0 : eff - int'(hysteresis);
      old = m_touch[ch];
      if (c >= eff) m_touch[ch] = 1'b1;
      else if (c < rel) m_touch[ch] = 1'b0;
`ifdef HM2_CAPSENSE_BASELINE_EN
      b = int'(m_base[ch]);
      if (!m_init) m_base[ch] = CW'(c);
      else if (!old) m_base[ch] = CW'(b + ((c - b) >>> SHF));
`endif
      e.base[ch] = m_base[ch];
    end
    m_init = 1'b1;
    e.tch  = m_touch;
    sb.push_back(e);

    n = 0;
    while (pad_oe !== '1 && n < 200) begin @(negedge clk); n++; end
    pad_in = '0;
    n = 0;
    while (pad_oe !== '0 && n < 100) begin @(negedge clk); n++; end
    cyc = 0;
    while (sample_valid !== 1'b1 && cyc < 2000) begin
      for (int ch = 0; ch < NCH; ch++)
        if (r[ch] == cyc) pad_in[ch] = 1'b1;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (sample_valid !== 1'b1) begin
      errors++;
      $display("FAIL scan_wait: sample_valid=%b after %0d cycles, required 1", sample_valid, cyc);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      for (int ch = 0; ch < NCH; ch++) begin
        checks++;
        if (count_out[ch*CW +: CW] !== e.cnt[ch]) begin
          errors++;
          $display("FAIL count ch%0d: got %0d required %0d", ch, count_out[ch*CW +: CW], e.cnt[ch]);
        end
`ifdef HM2_CAPSENSE_BASELINE_EN
        checks++;
        if (baseline_out[ch*CW +: CW] !== e.base[ch]) begin
          errors++;
          $display("FAIL baseline ch%0d: got %0d required %0d", ch, baseline_out[ch*CW +: CW], e.base[ch]);
        end
`endif
      end
      checks++;
      if (timeout !== e.tmo) begin
        errors++;
        $display("FAIL timeout: got %b required %b", timeout, e.tmo);
      end
      checks++;
      if (touched !== e.tch) begin
        errors++;
        $display("FAIL touched: got %b required %b", touched, e.tch);
      end
      @(negedge clk);
      checks++;
      if (sample_valid !== 1'b0) begin
        errors++;
        $display("FAIL valid_pulse: got %b required 0 one cycle later", sample_valid);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (pad_oe !== '0 || count_out !== '0 || timeout !== '0 || touched !== '0 || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: pad_oe=%b count_out=%h timeout=%b touched=%b valid=%b required all 0",
               tag, pad_oe, count_out, timeout, touched, sample_valid);
    end
  endtask

  task automatic check_quiet(input string tag, input int ncyc);
    int bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (pad_oe !== '0 || sample_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d cycles with pad_oe/sample_valid active, required 0", tag, bad);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; pad_in = '0;
    threshold = 16'd250; hysteresis = 16'd50;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;
    model_reset();
    check_quiet("idle_no_enable", 20);
  endtask

  task automatic test_counts();
    enable = 1'b1;
    run_scan(100, 200, 300, 400);
  endtask

  task automatic test_timeout();
    run_scan(50, 60, -1, 70);
  endtask

  task automatic test_hysteresis();
    run_scan(258, 10, 20, 30);
`ifndef HM2_CAPSENSE_BASELINE_EN
    checks++;
    if (touched[0] !== 1'b1) begin errors++; $display("FAIL hyst_260: got %b required 1", touched[0]); end
`endif
    run_scan(228, 10, 20, 30);
`ifndef HM2_CAPSENSE_BASELINE_EN
    checks++;
    if (touched[0] !== 1'b1) begin errors++; $display("FAIL hyst_230: got %b required 1", touched[0]); end
`endif
    run_scan(197, 10, 20, 30);
`ifndef HM2_CAPSENSE_BASELINE_EN
    checks++;
    if (touched[0] !== 1'b0) begin errors++; $display("FAIL hyst_199: got %b required 0", touched[0]); end
`endif
  endtask

  task automatic test_enable_drop();
    int n = 0;
    while (pad_oe !== '1 && n < 200) begin @(negedge clk); n++; end
    enable = 1'b0;
    run_scan(5, 6, 7, 8);
    check_quiet("idle_after_drop", 50);
  endtask

  task automatic test_reset_mid_charge();
    int n = 0;
    enable = 1'b1;
    while (pad_oe !== '1 && n < 200) begin @(negedge clk); n++; end
    pad_in = '0;
    n = 0;
    while (pad_oe !== '0 && n < 100) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("reset_mid_charge");
    reset = 1'b0; enable = 1'b0;
    model_reset();
    check_quiet("idle_after_reset", 30);
  endtask

`ifdef HM2_CAPSENSE_BASELINE_EN
  task automatic test_baseline();
    threshold = 16'd40; hysteresis = 16'd10; enable = 1'b1;
    run_scan(198, 198, 198, 198);
    checks++;
    if (baseline_out[CW-1:0] !== 16'd200 || touched[0] !== 1'b0) begin
      errors++; $display("FAIL base_200: base=%0d touched=%b required 200/0", baseline_out[CW-1:0], touched[0]);
    end
    run_scan(214, 214, 214, 214);
    checks++;
    if (baseline_out[CW-1:0] !== 16'd201 || touched[0] !== 1'b0) begin
      errors++; $display("FAIL base_201: base=%0d touched=%b required 201/0", baseline_out[CW-1:0], touched[0]);
    end
    run_scan(243, 214, 214, 214);
    checks++;
    if (touched[0] !== 1'b1) begin
      errors++; $display("FAIL base_touch: touched=%b required 1", touched[0]);
    end
    enable = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_counts();
    test_timeout();
    test_hysteresis();
    test_enable_drop();
    test_reset_mid_charge();
`ifdef HM2_CAPSENSE_BASELINE_EN
    test_baseline();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
